// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory.
// Holds the clear/ready state encoding, the word size and the address range check.
package dmem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int BYTES_PER_WORD = 8;

  // A full 8-byte word must fit; every bit of the 64-bit address takes part.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depthBytes);
    logic [63:0] limit;
    limit = 64'(depthBytes) - 64'(BYTES_PER_WORD);
    return addr <= limit;
  endfunction

endpackage

// File: rtl/data_memory_sat_counter.sv
// Saturating up-counter used for the memory's read and write access counts.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // Holds at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory with combinational loads, clocked stores,
// a post-reset zero-clear sequence, a sticky range error and access counters.
module data_memory #(
  parameter int DEPTH_BYTES    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          memAddr,
  input  logic [63:0]          memWriteData,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  output logic [63:0]          memReadData,
  output logic                 mem_ready,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count
);

  import dmem_pkg::*;

  localparam int ROWS  = DEPTH_BYTES / BYTES_PER_WORD;
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int PTR_W = $clog2(ROWS);

  logic [7:0]       mem_q [DEPTH_BYTES];
  state_e           state_q;
  logic [PTR_W-1:0] clr_ptr_q;
  logic             err_q;

  logic          inRange;
  logic          rdAcc;
  logic          wrAcc;
  logic          badAcc;
  logic [AW-1:0] base;
  logic [AW-1:0] clrBase;

  assign inRange   = addr_in_range(memAddr, DEPTH_BYTES);
  assign base      = memAddr[AW-1:0];
  assign clrBase   = AW'(int'(clr_ptr_q) * BYTES_PER_WORD);
  assign mem_ready = (state_q == READY);
  assign mem_err   = err_q;
  assign rdAcc     = mem_ready & MemRead & inRange;
  assign wrAcc     = mem_ready & MemWrite & inRange;
  assign badAcc    = mem_ready & (MemRead | MemWrite) & ~inRange;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + PTR_W'(1);
          if (!CLEAR_ON_RESET || (clr_ptr_q == PTR_W'(ROWS - 1))) begin
            state_q <= READY;
          end
        end
        READY: begin
          if (badAcc) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // The array has no reset; it is only zeroed by the clear walk once reset releases.
  always_ff @(posedge clk) begin
    if (rst && CLEAR_ON_RESET && (state_q == CLEAR)) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        mem_q[clrBase + AW'(i)] <= 8'h00;
      end
    end else if (wrAcc) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        mem_q[base + AW'(i)] <= memWriteData[8*i +: 8];
      end
    end
  end

  always_comb begin
    memReadData = '0;
    if (rdAcc) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        memReadData[8*i +: 8] = mem_q[base + AW'(i)];
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rdAcc),
    .count (rd_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wrAcc),
    .count (wr_count)
  );

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview: Byte-addressable data memory that sits directly downstream of the single-cycle datapath and consumes its memAddr, memWriteData, MemWrite and MemRead outputs. It returns memReadData combinationally for LDUR and commits STUR writes on the clock edge. After reset it zero-clears its array through an internal state machine and exposes mem_ready, so the top level can hold the PC while the clear runs. It also keeps a sticky out-of-range error flag and saturating read/write access counters for test visibility.

Parameters:
DEPTH_BYTES, 1024, array size in bytes; must be a multiple of 8 and at least 16
CLEAR_ON_RESET, 1, 1 = zero-clear the array after reset; 0 = go ready immediately
CNT_WIDTH, 32, width of the access counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
memAddr  input  64  byte address from the ALU result
memWriteData  input  64  store data, little-endian
MemWrite  input  1  store request
MemRead  input  1  load request
memReadData  output  64  load data, combinational
mem_ready  output  1  high when the array accepts accesses
mem_err  output  1  sticky flag for an out-of-range access
rd_count  output  CNT_WIDTH  count of accepted reads, saturating
wr_count  output  CNT_WIDTH  count of accepted writes, saturating

Behaviour:
- Reset (rst low, asynchronous):
  - state = CLEAR, clr_ptr = 0.
  - mem_ready = 0, mem_err = 0, rd_count = 0, wr_count = 0.
  - Array contents are not touched by the asynchronous reset.
- State machine, 2 states:
  - CLEAR: each clock zeroes bytes clr_ptr*8 .. clr_ptr*8+7, then increments clr_ptr.
  - CLEAR -> READY: on the clock that clears row DEPTH_BYTES/8-1.
  - mem_ready rises DEPTH_BYTES/8 clocks after rst deasserts.
  - CLEAR_ON_RESET = 0: CLEAR -> READY on the first clock after rst deasserts, with no clearing.
  - READY: stays in READY until the next reset.
  - Reset asserted mid-CLEAR restarts the clear from row 0.
- mem_ready = (state == READY), registered.
- In-range test: memAddr <= DEPTH_BYTES-8, compared at the full 64-bit width with no truncation. Unaligned addresses are legal.
- Read path:
  - memReadData = {byte[a+7], ..., byte[a]} when mem_ready & MemRead & in-range.
  - Otherwise memReadData = 0.
- Write path:
  - On a rising edge with mem_ready & MemWrite & in-range: byte[a+i] <= memWriteData[8i+7:8i] for i = 0..7.
  - Same-cycle read of overlapping bytes returns the old data (read-before-write).
- MemRead and MemWrite high together: the write commits, the read returns old data, and both counters increment.
- Out-of-range access (mem_ready high and MemRead or MemWrite high):
  - Write is dropped, read returns 0.
  - mem_err is set on the next edge and stays set until reset.
- Accesses while mem_ready = 0: ignored; no write, read returns 0, no counter change, no error.
- Counters:
  - rd_count / wr_count increment once per clock with an accepted, in-range read / write.
  - They saturate at all-ones and do not wrap.

Decomposition:
- Package dmem_pkg holds:
  - state enum {CLEAR, READY}
  - BYTES_PER_WORD = 8
  - the in-range helper function
- One sub-module, sat_counter (parameter CNT_WIDTH; ports clk, rst, inc, count), instantiated twice for rd_count and wr_count.

Test Plan:
- Clear sequence: DEPTH_BYTES = 64, release rst -> mem_ready low for exactly 8 clocks then high; reading 0x0, 0x20 and 0x38 returns 0.
- Store/load: STUR 0x1122334455667788 at 0x10, then LDUR 0x10 -> same value; LDUR 0x13 -> 0x??????1122334455, with the upper bytes taken from 0x18..0x1A.
- Read-before-write: address 0x8 holds 0xAAAA...; MemRead and MemWrite with 0x5555... at 0x8 in the same cycle -> memReadData = 0xAAAA... that cycle, 0x5555... the next cycle; rd_count = 1 and wr_count = 1.
- Bounds (DEPTH_BYTES = 64):
  - Write at 0x39 -> dropped, mem_err = 1 on the next edge; address 0x38 is unchanged.
  - Read at 0xFFFF_FFFF_0000_0000 -> returns 0, no counter change.
- Gating and reset: access during CLEAR -> ignored, counters stay 0; assert rst mid-CLEAR (row 3) -> clear restarts, mem_ready low for a full 8 clocks; mem_err and counters return to 0.
- Saturation: CNT_WIDTH = 4, 20 reads -> rd_count holds at 15.
